// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bridge: FSM state encoding,
// command byte layout and the default idle transmit byte.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DROP  = 3'd4
    } state_e;

    localparam int         CMD_WRITE_BIT   = 7;
    localparam logic [7:0] IDLE_TX_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_reg_file.sv
// Register file for the SPI bridge: one synchronous write port, one
// combinational read port, a flat view of all registers, sync reset.
// Ports: clk_i, rst_i, we_i/waddr_i/wdata_i (write), raddr_i/rdata_o
// (read), regs_flat_o (reg i at bits [8i+7:8i]).
module spi_reg_file #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [7:0]            rdata_o,
    output logic [NUM_REGS*8-1:0] regs_flat_o
);

    logic [7:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

    always_comb begin
        regs_flat_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat_o[8*i +: 8] = regs_q[i];
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Command decoder behind the SPI slave byte receiver. The first byte of
// a frame is a command (bit 7 = write, [6:0] = address); following bytes
// are burst-written or burst-read with an auto-incrementing pointer.
// Ports: clk, rst, frame_start/frame_end (CS pulses), rx_valid/rx_data
// (received byte), tx_data (next byte to shift out), wr_strobe/wr_addr/
// wr_data (write notification), regs_flat, err (sticky), led (reg0 bit0).
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter int         ADDR_W   = 3,
    parameter logic [7:0] IDLE_TX  = IDLE_TX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [7:0]            tx_data,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  err,
    output logic                  led
);

    localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        tx_q;
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              err_q;

    logic              rx_take;
    logic              we;
    logic              cmd_ok;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] raddr;
    logic [7:0]        rdata;

    // A byte coinciding with frame_start belongs to no command: discard it.
    assign rx_take  = rx_valid && !frame_start;
    assign we       = rx_take && (state_q == ST_WRITE);
    assign cmd_ok   = {1'b0, rx_data[6:0]} < NREGS8;
    assign cmd_addr = rx_data[ADDR_W-1:0];
    // NUM_REGS is a power of two, so natural overflow gives the wrap.
    assign ptr_inc  = ptr_q + ADDR_W'(1);
    // Read port serves the command's start address, then ptr+1 in a burst.
    assign raddr    = (state_q == ST_CMD) ? cmd_addr : ptr_inc;

    spi_reg_file #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_file (
        .clk_i       (clk),
        .rst_i       (rst),
        .we_i        (we),
        .waddr_i     (ptr_q),
        .wdata_i     (rx_data),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .regs_flat_o (regs_flat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            tx_q        <= IDLE_TX;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (rx_take) begin
                case (state_q)
                    ST_CMD: begin
                        if (!cmd_ok) begin
                            state_q <= ST_DROP;
                            err_q   <= 1'b1;
                            tx_q    <= IDLE_TX;
                        end else if (rx_data[CMD_WRITE_BIT]) begin
                            ptr_q   <= cmd_addr;
                            state_q <= ST_WRITE;
                        end else begin
                            ptr_q   <= cmd_addr;
                            tx_q    <= rdata;
                            state_q <= ST_READ;
                        end
                    end
                    ST_WRITE: begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= ptr_q;
                        wr_data_q   <= rx_data;
                        ptr_q       <= ptr_inc;
                        // Writing reg 0 with bit 7 set acknowledges err.
                        if (ptr_q == '0 && rx_data[7]) begin
                            err_q <= 1'b0;
                        end
                    end
                    ST_READ: begin
                        ptr_q <= ptr_inc;
                        tx_q  <= rdata;
                    end
                    default: begin
                    end
                endcase
            end
            // Frame pulses override the state after the byte is handled.
            if (frame_start) begin
                state_q <= ST_CMD;
                tx_q    <= IDLE_TX;
            end else if (frame_end) begin
                state_q <= ST_IDLE;
                tx_q    <= IDLE_TX;
            end
        end
    end

    assign tx_data   = tx_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign err       = err_q;
    assign led       = regs_flat[0];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge: write, wrapping burst,
// read burst, bad address/err clear, frame overlaps and mid-frame reset.
module tb_spi_reg_bridge;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        frame_end;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        wr_strobe;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [63:0] regs_flat;
    logic        err;
    logic        led;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    spi_reg_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .regs_flat   (regs_flat),
        .err         (err),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic fend();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (regs_flat !== 64'h0) begin errors++; $display("FAIL rst_regs: got %h exp %h", regs_flat, 64'h0); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL rst_tx: got %h exp a5", tx_data); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b exp 0", wr_strobe); end
        checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL rst_waddr: got %h exp 0", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h exp 00", wr_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL rst_led: got %b exp 0", led); end
    endtask

    task automatic test_write();
        int s0;
        s0 = strobes;
        fstart();
        send(8'h82);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wr_cmd_strobe: got %b exp 0", wr_strobe); end
        send(8'h3C);
        checks++; if (wr_strobe !== 1'b1) begin errors++; $display("FAIL wr_strobe: got %b exp 1", wr_strobe); end
        checks++; if (wr_addr !== 3'd2) begin errors++; $display("FAIL wr_addr: got %h exp 2", wr_addr); end
        checks++; if (wr_data !== 8'h3C) begin errors++; $display("FAIL wr_data: got %h exp 3c", wr_data); end
        checks++; if (regs_flat[23:16] !== 8'h3C) begin errors++; $display("FAIL wr_reg2: got %h exp 3c", regs_flat[23:16]); end
        fend();
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL wr_pulse_len: got %b exp 0", wr_strobe); end
        checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL wr_strobe_cnt: got %0d exp 1", strobes - s0); end
        checks++; if (regs_flat !== 64'h0000_0000_003C_0000) begin errors++; $display("FAIL wr_regs: got %h exp %h", regs_flat, 64'h0000_0000_003C_0000); end
    endtask

    task automatic test_burst_wrap();
        fstart();
        send(8'h86);
        send(8'h11);
        checks++; if (regs_flat[55:48] !== 8'h11) begin errors++; $display("FAIL bw_reg6: got %h exp 11", regs_flat[55:48]); end
        send(8'h22);
        send(8'h33);
        checks++; if (wr_addr !== 3'd0) begin errors++; $display("FAIL bw_wrap_addr: got %h exp 0", wr_addr); end
        checks++; if (wr_data !== 8'h33) begin errors++; $display("FAIL bw_wrap_data: got %h exp 33", wr_data); end
        fend();
        checks++; if (regs_flat !== 64'h2211_0000_003C_0033) begin errors++; $display("FAIL bw_regs: got %h exp %h", regs_flat, 64'h2211_0000_003C_0033); end
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL bw_led: got %b exp 1", led); end
    endtask

    task automatic test_read();
        int s0;
        fstart();
        send(8'h83);
        send(8'h44);
        send(8'h55);
        fend();
        checks++; if (regs_flat !== 64'h2211_0055_443C_0033) begin errors++; $display("FAIL rd_preload: got %h exp %h", regs_flat, 64'h2211_0055_443C_0033); end
        s0 = strobes;
        fstart();
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL rd_idle_tx: got %h exp a5", tx_data); end
        send(8'h03);
        checks++; if (tx_data !== 8'h44) begin errors++; $display("FAIL rd_tx0: got %h exp 44", tx_data); end
        send(8'h00);
        checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL rd_tx1: got %h exp 55", tx_data); end
        send(8'hFF);
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rd_tx2: got %h exp 00", tx_data); end
        fend();
        fstart();
        send(8'h07);
        checks++; if (tx_data !== 8'h22) begin errors++; $display("FAIL rd_tx7: got %h exp 22", tx_data); end
        send(8'h00);
        checks++; if (tx_data !== 8'h33) begin errors++; $display("FAIL rd_wrap_tx: got %h exp 33", tx_data); end
        fend();
        checks++; if (strobes !== s0) begin errors++; $display("FAIL rd_no_strobe: got %0d exp %0d", strobes, s0); end
        checks++; if (regs_flat !== 64'h2211_0055_443C_0033) begin errors++; $display("FAIL rd_regs: got %h exp %h", regs_flat, 64'h2211_0055_443C_0033); end
    endtask

    task automatic test_bad_addr();
        int s0;
        s0 = strobes;
        fstart();
        send(8'h8F);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ba_err_set: got %b exp 1", err); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL ba_tx0: got %h exp a5", tx_data); end
        send(8'hFF);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL ba_strobe: got %b exp 0", wr_strobe); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL ba_tx1: got %h exp a5", tx_data); end
        fend();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ba_err_sticky: got %b exp 1", err); end
        checks++; if (strobes !== s0) begin errors++; $display("FAIL ba_strobe_cnt: got %0d exp %0d", strobes, s0); end
        checks++; if (regs_flat !== 64'h2211_0055_443C_0033) begin errors++; $display("FAIL ba_regs: got %h exp %h", regs_flat, 64'h2211_0055_443C_0033); end
        fstart();
        send(8'h80);
        send(8'h80);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ba_err_clr: got %b exp 0", err); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL ba_led: got %b exp 0", led); end
        fend();
        checks++; if (regs_flat !== 64'h2211_0055_443C_0080) begin errors++; $display("FAIL ba_regs_clr: got %h exp %h", regs_flat, 64'h2211_0055_443C_0080); end
        fstart();
        send(8'h08);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ba_addr8_err: got %b exp 1", err); end
        send(8'h00);
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL ba_addr8_tx: got %h exp a5", tx_data); end
        fend();
        fstart();
        send(8'h80);
        send(8'h80);
        fend();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ba_err_clr2: got %b exp 0", err); end
    endtask

    task automatic test_frame_overlap();
        int s0;
        s0 = strobes;
        frame_start = 1'b1;
        rx_valid    = 1'b1;
        rx_data     = 8'h8F;
        tick();
        frame_start = 1'b0;
        rx_valid    = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ov_start_drop: got err %b exp 0", err); end
        send(8'h81);
        rx_valid  = 1'b1;
        rx_data   = 8'h07;
        frame_end = 1'b1;
        tick();
        rx_valid  = 1'b0;
        frame_end = 1'b0;
        checks++; if (wr_strobe !== 1'b1) begin errors++; $display("FAIL ov_end_strobe: got %b exp 1", wr_strobe); end
        checks++; if (wr_addr !== 3'd1) begin errors++; $display("FAIL ov_end_addr: got %h exp 1", wr_addr); end
        checks++; if (regs_flat[15:8] !== 8'h07) begin errors++; $display("FAIL ov_reg1: got %h exp 07", regs_flat[15:8]); end
        send(8'h99);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL ov_idle_strobe: got %b exp 0", wr_strobe); end
        tick();
        checks++; if (strobes - s0 !== 1) begin errors++; $display("FAIL ov_strobe_cnt: got %0d exp 1", strobes - s0); end
        checks++; if (regs_flat !== 64'h2211_0055_443C_0780) begin errors++; $display("FAIL ov_regs: got %h exp %h", regs_flat, 64'h2211_0055_443C_0780); end
    endtask

    task automatic test_mid_reset();
        int s0;
        fstart();
        send(8'h90);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mr_err_pre: got %b exp 1", err); end
        fstart();
        send(8'h80);
        send(8'h01);
        checks++; if (led !== 1'b1) begin errors++; $display("FAIL mr_led_pre: got %b exp 1", led); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (regs_flat !== 64'h0) begin errors++; $display("FAIL mr_regs: got %h exp 0", regs_flat); end
        checks++; if (led !== 1'b0) begin errors++; $display("FAIL mr_led: got %b exp 0", led); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL mr_tx: got %h exp a5", tx_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mr_err: got %b exp 0", err); end
        s0 = strobes;
        send(8'h42);
        send(8'h80);
        send(8'h01);
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL mr_post_strobe: got %b exp 0", wr_strobe); end
        tick();
        checks++; if (strobes !== s0) begin errors++; $display("FAIL mr_strobe_cnt: got %0d exp %0d", strobes, s0); end
        checks++; if (regs_flat !== 64'h0) begin errors++; $display("FAIL mr_regs_post: got %h exp 0", regs_flat); end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        test_reset();
        test_write();
        test_burst_wrap();
        test_read();
        test_bad_addr();
        test_frame_overlap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
